// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   Input digits are captured into a staging buffer on load. They are copied
//   to the shadow buffer only at the frame wrap, so a frame never mixes old
//   and new digits. All display outputs are registered from (idx, shadow).
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   en          display enable (0 = all anodes off; scanning keeps running)
//   digits      digit i on [4i+3:4i], digit 0 rightmost
//   dp_in       decimal point per digit, 1 = lit
//   lzb         leading-zero blanking enable
//   load        one-cycle strobe capturing digits/dp_in into staging
//   seg         active-low segments {g,f,e,d,c,b,a}
//   dp          active-low decimal point
//   an          active-low anode select, at most one bit low
//   digit_idx   index of the digit currently driven on seg/an
//   frame_done  one-cycle pulse after the scan wraps to digit 0
//   upd_pending staging holds data not yet shown
module seven_seg_scan_driver #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          HEX_MODE    = 1'b0,
    localparam int unsigned IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lzb,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done,
    output logic                  upd_pending
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] stg_dig_q, stg_dig_d;
    logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [4*N_DIGITS-1:0] shd_dig_q, shd_dig_d;
    logic [N_DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic                  upd_pending_q, upd_pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;

    logic       tick;
    logic       last_digit;
    logic       wrap;
    logic [3:0] cur_val;
    logic       cur_dp;
    logic       nonzero_above;
    logic       blank;

    function automatic logic [6:0] decode7(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = HEX_MODE ? 7'h08 : 7'h7F;
            4'hB:    g = HEX_MODE ? 7'h03 : 7'h7F;
            4'hC:    g = HEX_MODE ? 7'h46 : 7'h7F;
            4'hD:    g = HEX_MODE ? 7'h21 : 7'h7F;
            4'hE:    g = HEX_MODE ? 7'h06 : 7'h7F;
            default: g = HEX_MODE ? 7'h0E : 7'h7F;
        endcase
        return g;
    endfunction

    // Refresh divider and digit scan
    always_comb begin
        tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        last_digit = (idx_q == IDX_W'(N_DIGITS - 1));
        wrap       = tick && last_digit;
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (tick) begin
            idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Staging/shadow double buffer. Staging always takes a load, even on the
    // wrap edge, so it keeps matching shadow and a later wrap cannot revert it.
    always_comb begin
        stg_dig_d     = load ? digits : stg_dig_q;
        stg_dp_d      = load ? dp_in  : stg_dp_q;
        shd_dig_d     = shd_dig_q;
        shd_dp_d      = shd_dp_q;
        upd_pending_d = upd_pending_q;
        frame_done_d  = wrap;
        if (wrap) begin
            shd_dig_d     = load ? digits : stg_dig_q;
            shd_dp_d      = load ? dp_in  : stg_dp_q;
            upd_pending_d = 1'b0;
        end else if (load) begin
            upd_pending_d = 1'b1;
        end
    end

    // Output decode from the current idx and shadow
    always_comb begin
        cur_val       = '0;
        cur_dp        = 1'b0;
        nonzero_above = 1'b0;
        an_d          = '1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_val = shd_dig_q[4*i +: 4];
                cur_dp  = shd_dp_q[i];
                an_d[i] = ~en;
            end
            // Any nonzero digit at or above the current one stops blanking
            if ((i >= 32'(idx_q)) && (shd_dig_q[4*i +: 4] != 4'h0)) begin
                nonzero_above = 1'b1;
            end
        end
        blank       = lzb && (idx_q != '0) && !nonzero_above;
        seg_d       = (en && !blank) ? decode7(cur_val) : 7'h7F;
        dp_d        = en ? ~cur_dp : 1'b1;
        digit_idx_d = idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            stg_dig_q     <= '0;
            stg_dp_q      <= '0;
            shd_dig_q     <= '0;
            shd_dp_q      <= '0;
            upd_pending_q <= 1'b0;
            frame_done_q  <= 1'b0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            an_q          <= '1;
            digit_idx_q   <= '0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stg_dig_q     <= stg_dig_d;
            stg_dp_q      <= stg_dp_d;
            shd_dig_q     <= shd_dig_d;
            shd_dp_q      <= shd_dp_d;
            upd_pending_q <= upd_pending_d;
            frame_done_q  <= frame_done_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            digit_idx_q   <= digit_idx_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign digit_idx   = digit_idx_q;
    assign frame_done  = frame_done_q;
    assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

    localparam int N_D = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset, en, lzb, load;
    logic [15:0] digits;
    logic [3:0]  dp_in;

    logic [6:0] seg, seg_h;
    logic       dp, dp_h;
    logic [3:0] an, an_h;
    logic [1:0] didx, didx_h;
    logic       fd, fd_h, pend, pend_h;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.N_DIGITS(N_D), .REFRESH_DIV(DIV), .HEX_MODE(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .digits(digits), .dp_in(dp_in),
        .lzb(lzb), .load(load), .seg(seg), .dp(dp), .an(an), .digit_idx(didx),
        .frame_done(fd), .upd_pending(pend)
    );

    seven_seg_scan_driver #(.N_DIGITS(N_D), .REFRESH_DIV(DIV), .HEX_MODE(1'b1)) dut_hex (
        .clk(clk), .reset(reset), .en(en), .digits(digits), .dp_in(dp_in),
        .lzb(lzb), .load(load), .seg(seg_h), .dp(dp_h), .an(an_h), .digit_idx(didx_h),
        .frame_done(fd_h), .upd_pending(pend_h)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_cnt, m_idx;
    int         m_stg[N_D], m_shd[N_D];
    bit         m_stg_dp[N_D], m_shd_dp[N_D];
    bit         m_pend, m_fd;
    logic [6:0] e_seg, e_segh;
    logic       e_dp;
    logic [3:0] e_an;
    int         e_idx;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp_in;
        logic        lzb;
        logic [27:0] seg;   // expected seg per digit, digit i at [7i+6:7i], HEX_MODE=0
        logic [27:0] segh;  // same for HEX_MODE=1
        logic [3:0]  dpo;   // expected active-low dp per digit
    } vec_t;
    vec_t vt[7];

    function automatic logic [6:0] glyph(input int v, input bit hex);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            10: return hex ? 7'h08 : 7'h7F;
            11: return hex ? 7'h03 : 7'h7F;
            12: return hex ? 7'h46 : 7'h7F;
            13: return hex ? 7'h21 : 7'h7F;
            14: return hex ? 7'h06 : 7'h7F;
            15: return hex ? 7'h0E : 7'h7F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pend = 0; m_fd = 0;
        for (int j = 0; j < N_D; j++) begin
            m_stg[j] = 0; m_shd[j] = 0; m_stg_dp[j] = 0; m_shd_dp[j] = 0;
        end
        e_seg = 7'h7F; e_segh = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_idx = 0;
    endtask

    // One clock edge of the display as described: outputs reflect the digit
    // being scanned before the edge; buffers and scan position then advance.
    task automatic model_step();
        bit blank, wrap;
        logic [3:0] a;
        blank = 0;
        if (lzb && m_idx > 0) begin
            blank = 1;
            for (int j = m_idx; j < N_D; j++) if (m_shd[j] != 0) blank = 0;
        end
        a = 4'hF;
        a[m_idx] = 1'b0;
        if (en) begin
            e_seg  = blank ? 7'h7F : glyph(m_shd[m_idx], 1'b0);
            e_segh = blank ? 7'h7F : glyph(m_shd[m_idx], 1'b1);
            e_dp   = ~m_shd_dp[m_idx];
            e_an   = a;
        end else begin
            e_seg = 7'h7F; e_segh = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end
        e_idx = m_idx;
        wrap  = (m_cnt == DIV - 1) && (m_idx == N_D - 1);
        m_fd  = wrap;
        if (wrap) begin
            for (int j = 0; j < N_D; j++) begin
                m_shd[j]    = load ? int'(digits[4*j +: 4]) : m_stg[j];
                m_shd_dp[j] = load ? dp_in[j] : m_stg_dp[j];
            end
            m_pend = 0;
        end else if (load) begin
            m_pend = 1;
        end
        if (load) begin
            for (int j = 0; j < N_D; j++) begin
                m_stg[j]    = int'(digits[4*j +: 4]);
                m_stg_dp[j] = dp_in[j];
            end
        end
        m_cnt++;
        if (m_cnt == DIV) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % N_D;
        end
    endtask

    task automatic compare_all();
        check("seg", seg, e_seg);
        check("seg_hex", seg_h, e_segh);
        check("dp", dp, e_dp);
        check("dp_hex", dp_h, e_dp);
        check("an", an, e_an);
        check("an_hex", an_h, e_an);
        check("digit_idx", didx, e_idx);
        check("digit_idx_hex", didx_h, e_idx);
        check("frame_done", fd, m_fd);
        check("frame_done_hex", fd_h, m_fd);
        check("upd_pending", pend, m_pend);
        check("upd_pending_hex", pend_h, m_pend);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Runs until a frame_done is seen, then records what each digit shows
    task automatic capture_frame(output logic [27:0] s, output logic [27:0] sh, output logic [3:0] d);
        bit seen;
        seen = 0;
        s = 'x; sh = 'x; d = 'x;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (seen) begin
                for (int i = 0; i < N_D; i++) begin
                    if (an[i] == 1'b0) begin
                        s[7*i +: 7]  = seg;
                        sh[7*i +: 7] = seg_h;
                        d[i]         = dp;
                    end
                end
            end
            if (fd) seen = 1;
        end
    endtask

    task automatic wait_fd();
        bit got;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            cycle();
            if (fd) got = 1;
        end
        if (!got) check("wait_frame_done_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] cs, csh;
        logic [3:0]  cd;
        int          first_fd, second_fd;

        vt[0] = '{16'h1234, 4'b0100, 1'b0, {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}, 4'b1011};
        vt[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F,7'h7F,7'h12,7'h40}, {7'h7F,7'h7F,7'h12,7'h40}, 4'b1111};
        vt[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'b1111};
        vt[3] = '{16'h00AF, 4'b0000, 1'b0, {7'h40,7'h40,7'h7F,7'h7F}, {7'h40,7'h40,7'h08,7'h0E}, 4'b1111};
        vt[4] = '{16'h8967, 4'b1001, 1'b1, {7'h00,7'h10,7'h02,7'h78}, {7'h00,7'h10,7'h02,7'h78}, 4'b0110};
        vt[5] = '{16'h0BCD, 4'b0010, 1'b1, {7'h7F,7'h7F,7'h7F,7'h7F}, {7'h7F,7'h03,7'h46,7'h21}, 4'b1101};
        vt[6] = '{16'h0E00, 4'b1000, 1'b1, {7'h7F,7'h7F,7'h40,7'h40}, {7'h7F,7'h06,7'h40,7'h40}, 4'b0111};

        reset = 1'b1; en = 1'b0; lzb = 1'b0; load = 1'b0; digits = '0; dp_in = '0;
        model_reset();
        #2;
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_an", an, 4'hF);
        check("reset_pending", pend, 1'b0);
        check("reset_frame_done", fd, 1'b0);
        check("reset_digit_idx", didx, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b1;

        // Idle scan after reset: first edge lights digit 0 with '0', frame every 16 cycles
        first_fd = -1; second_fd = -1;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            if (c == 1) begin
                check("first_edge_an", an, 4'hE);
                check("first_edge_seg", seg, 7'h40);
            end
            if (fd) begin
                if (first_fd < 0) first_fd = c;
                else if (second_fd < 0) second_fd = c;
            end
        end
        check("first_frame_done_cycle", first_fd, 16);
        check("frame_done_period", second_fd - first_fd, 16);

        // Table-driven display patterns
        for (int v = 0; v < 7; v++) begin
            digits = vt[v].digits; dp_in = vt[v].dp_in; lzb = vt[v].lzb;
            load = 1'b1;
            cycle();
            load = 1'b0;
            capture_frame(cs, csh, cd);
            for (int i = 0; i < N_D; i++) begin
                check($sformatf("vec%0d_seg_d%0d", v, i), cs[7*i +: 7], vt[v].seg[7*i +: 7]);
                check($sformatf("vec%0d_seghex_d%0d", v, i), csh[7*i +: 7], vt[v].segh[7*i +: 7]);
                check($sformatf("vec%0d_dp_d%0d", v, i), cd[i], vt[v].dpo[i]);
            end
        end

        // Two loads in one frame: last one wins
        lzb = 1'b0; dp_in = '0;
        wait_fd();
        digits = 16'h1111; load = 1'b1; cycle(); load = 1'b0;
        check("two_load_pending", pend, 1'b1);
        cycle(); cycle(); cycle();
        digits = 16'h2222; load = 1'b1; cycle(); load = 1'b0;
        check("two_load_pending2", pend, 1'b1);
        check("two_load_still_old_an", an[0] == 1'b0 || an[1] == 1'b0, 1'b1);
        capture_frame(cs, csh, cd);
        for (int i = 0; i < N_D; i++)
            check($sformatf("two_load_seg_d%0d", i), cs[7*i +: 7], 7'h24);
        check("two_load_pending_cleared", pend, 1'b0);

        // Load on the wrap edge goes straight to the frame that starts there
        for (int k = 0; k < 40; k++) begin
            if (m_cnt == DIV - 1 && m_idx == N_D - 1) break;
            cycle();
        end
        check("wrap_edge_found", (m_cnt == DIV - 1) && (m_idx == N_D - 1), 1);
        digits = 16'h5678; load = 1'b1;
        cycle();
        load = 1'b0;
        check("wrap_load_pending", pend, 1'b0);
        check("wrap_load_frame_done", fd, 1'b1);
        cycle();
        check("wrap_load_d0_an", an, 4'hE);
        check("wrap_load_d0_seg", seg, 7'h00);
        for (int k = 0; k < 4; k++) cycle();
        check("wrap_load_d1_an", an, 4'hD);
        check("wrap_load_d1_seg", seg, 7'h78);

        // Display disabled: anodes off, scan and frame_done continue (model-checked)
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("en0_an", an, 4'hF);
        end
        en = 1'b1;

        // Async reset mid-frame with a load pending
        wait_fd();
        for (int k = 0; k < 5; k++) cycle();
        digits = 16'h9999; load = 1'b1; cycle(); load = 1'b0;
        cycle(); cycle();
        check("pre_reset_pending", pend, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_reset_seg", seg, 7'h7F);
        check("mid_reset_an", an, 4'hF);
        check("mid_reset_pending", pend, 1'b0);
        check("mid_reset_dp", dp, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        check("post_reset_an", an, 4'hE);
        check("post_reset_seg", seg, 7'h40);
        capture_frame(cs, csh, cd);
        for (int i = 0; i < N_D; i++)
            check($sformatf("post_reset_seg_d%0d", i), cs[7*i +: 7], 7'h40);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            en     = ($urandom_range(0, 7) != 0);
            lzb    = $urandom_range(0, 1) == 1;
            load   = ($urandom_range(0, 5) == 0);
            digits = 16'($urandom);
            dp_in  = 4'($urandom);
            cycle();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
